// File: rtl/reg_exec_pkg.sv
// Shared definitions for the register-file execute sequencer: opcodes,
// FSM state encoding and instruction field positions.
package reg_exec_pkg;

    localparam int INSTR_WIDTH = 16;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LDI = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 13;
    localparam int RD_BIT  = 12;
    localparam int RS1_BIT = 11;
    localparam int RS2_BIT = 10;
    localparam int RSV_MSB = 9;
    localparam int RSV_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational 8-bit ALU used in the EXEC state; wrap-around arithmetic,
// carry passes through unchanged for opcodes that do not define it.
module seq_alu
    import reg_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OPC_WIDTH  = 3
) (
    input  logic [OPC_WIDTH-1:0]  opcode,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  carry_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    // The extra MSB of the zero-extended difference is the borrow (a < b).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result    = '0;
        carry_out = carry_in;
        case (opcode)
            OP_ADD: begin
                result    = sum[DATA_WIDTH-1:0];
                carry_out = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                result    = diff[DATA_WIDTH-1:0];
                carry_out = diff[DATA_WIDTH];
            end
            OP_AND: begin
                result    = a & b;
                carry_out = 1'b0;
            end
            OP_OR: begin
                result    = a | b;
                carry_out = 1'b0;
            end
            OP_XOR: begin
                result    = a ^ b;
                carry_out = 1'b0;
            end
            OP_LDI: result = imm;
            OP_SHL: begin
                result    = {a[DATA_WIDTH-2:0], 1'b0};
                carry_out = a[DATA_WIDTH-1];
            end
            default: begin
                result    = '0;
                carry_out = carry_in;
            end
        endcase
    end

endmodule

// File: rtl/reg_exec_sequencer.sv
// Four-state execute controller: latches one instruction, reads two registers,
// runs the ALU and writes the result back to a 2-entry register file.
module reg_exec_sequencer
    import reg_exec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OPC_WIDTH  = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    input  logic [15:0]           instr,
    output logic                  read_register1,
    output logic                  read_register2,
    input  logic [DATA_WIDTH-1:0] read_data1,
    input  logic [DATA_WIDTH-1:0] read_data2,
    output logic                  write_enable,
    output logic                  write_register,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero_flag,
    output logic                  carry_flag
);

    state_t                state;
    logic [OPC_WIDTH-1:0]  opcode_q;
    logic                  rd_q;
    logic                  rs1_q;
    logic                  rs2_q;
    logic [DATA_WIDTH-1:0] imm_q;
    logic [DATA_WIDTH-1:0] opnd_a_p1;
    logic [DATA_WIDTH-1:0] opnd_b_p1;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_carry;
    logic                  unused_rsvd;

    // Reserved instruction bits carry no meaning and are dropped at the port.
    assign unused_rsvd = ^instr[RSV_MSB:RSV_LSB];

    assign read_register1 = rs1_q;
    assign read_register2 = rs2_q;
    assign write_register = rd_q;

    seq_alu #(
        .DATA_WIDTH (DATA_WIDTH),
        .OPC_WIDTH  (OPC_WIDTH)
    ) u_alu (
        .opcode    (opcode_q),
        .a         (opnd_a_p1),
        .b         (opnd_b_p1),
        .imm       (imm_q),
        .carry_in  (carry_flag),
        .result    (alu_result),
        .carry_out (alu_carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            instr_ready  <= 1'b1;
            write_enable <= 1'b0;
            done         <= 1'b0;
            result       <= '0;
            write_data   <= '0;
            zero_flag    <= 1'b0;
            carry_flag   <= 1'b0;
            opcode_q     <= '0;
            rd_q         <= 1'b0;
            rs1_q        <= 1'b0;
            rs2_q        <= 1'b0;
            imm_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        opcode_q    <= instr[OPC_MSB:OPC_LSB];
                        rd_q        <= instr[RD_BIT];
                        rs1_q       <= instr[RS1_BIT];
                        rs2_q       <= instr[RS2_BIT];
                        imm_q       <= instr[IMM_MSB:IMM_LSB];
                        instr_ready <= 1'b0;
                        state       <= ST_READ;
                    end
                end
                ST_READ: state <= ST_EXEC;
                ST_EXEC: begin
                    // NOP still completes with a done pulse but touches nothing.
                    if (opcode_q != OP_NOP) begin
                        result       <= alu_result;
                        write_data   <= alu_result;
                        zero_flag    <= (alu_result == '0);
                        carry_flag   <= alu_carry;
                        write_enable <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    write_enable <= 1'b0;
                    done         <= 1'b0;
                    instr_ready  <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // read stage -> exec stage: operand capture from the register file
    always_ff @(posedge clock) begin
        if (state == ST_READ) begin
            opnd_a_p1 <= read_data1;
            opnd_b_p1 <= read_data2;
        end
    end

endmodule

// File: tb/tb_reg_exec_sequencer.sv
// Self-checking bench: directed scenarios plus randomized instructions against
// an arithmetic reference model, with a behavioural 2-entry register file.
module tb_reg_exec_sequencer;

    logic        clock;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        read_register1;
    logic        read_register2;
    logic [7:0]  read_data1;
    logic [7:0]  read_data2;
    logic        write_enable;
    logic        write_register;
    logic [7:0]  write_data;
    logic        done;
    logic [7:0]  result;
    logic        zero_flag;
    logic        carry_flag;

    logic [7:0] rf [0:1];
    logic [7:0] exp_rf [0:1];
    logic [7:0] exp_result;
    logic       exp_zero;
    logic       exp_carry;

    int tests;
    int fails;

    reg_exec_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .read_register1 (read_register1),
        .read_register2 (read_register2),
        .read_data1     (read_data1),
        .read_data2     (read_data2),
        .write_enable   (write_enable),
        .write_register (write_register),
        .write_data     (write_data),
        .done           (done),
        .result         (result),
        .zero_flag      (zero_flag),
        .carry_flag     (carry_flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign read_data1 = rf[read_register1];
    assign read_data2 = rf[read_register2];

    always @(posedge clock) begin
        if (write_enable) rf[write_register] <= write_data;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference ALU: {carry, result} from plain integer arithmetic.
    function automatic logic [8:0] ref_alu(input int op, input int a, input int b,
                                           input int imm, input logic cin);
        int   r;
        logic c;
        r = 0;
        c = cin;
        case (op)
            1: begin r = (a + b) % 256; c = (a + b) > 255; end
            2: begin r = (a - b + 256) % 256; c = (a < b); end
            3: begin r = a & b; c = 1'b0; end
            4: begin r = a | b; c = 1'b0; end
            5: begin r = a ^ b; c = 1'b0; end
            6: r = imm;
            7: begin r = (a * 2) % 256; c = (a >= 128); end
            default: begin r = 0; c = cin; end
        endcase
        return {c, 8'(r)};
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (instr_ready !== 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check("ready_wait", 16'(instr_ready), 16'd1);
    endtask

    // One full instruction; noise keeps instr_valid high with junk while busy.
    task automatic run(input int op, input bit rd, input bit rs1, input bit rs2,
                       input logic [7:0] imm, input bit noise);
        logic [8:0] ref_out;
        wait_ready();
        instr       = {3'(op), rd, rs1, rs2, 2'(($urandom)), imm};
        instr_valid = 1'b1;
        ref_out     = ref_alu(op, int'(exp_rf[rs1]), int'(exp_rf[rs2]), int'(imm), exp_carry);
        @(negedge clock);
        instr_valid = noise;
        if (noise) instr = 16'($urandom);
        check("read_ready", 16'(instr_ready), 16'd0);
        check("read_rs1", 16'(read_register1), 16'(rs1));
        check("read_rs2", 16'(read_register2), 16'(rs2));
        check("read_we", 16'(write_enable), 16'd0);
        @(negedge clock);
        check("exec_we", 16'(write_enable), 16'd0);
        check("exec_done", 16'(done), 16'd0);
        @(negedge clock);
        if (op != 0) begin
            exp_result = ref_out[7:0];
            exp_zero   = (ref_out[7:0] == 8'd0);
            exp_carry  = ref_out[8];
            check("write_reg", 16'(write_register), 16'(rd));
            check("write_data", 16'(write_data), 16'(ref_out[7:0]));
        end
        check("write_we", 16'(write_enable), 16'(op != 0));
        check("write_done", 16'(done), 16'd1);
        check("write_rs1_hold", 16'(read_register1), 16'(rs1));
        check("result", 16'(result), 16'(exp_result));
        check("zero_flag", 16'(zero_flag), 16'(exp_zero));
        check("carry_flag", 16'(carry_flag), 16'(exp_carry));
        instr_valid = 1'b0;
        @(negedge clock);
        if (op != 0) exp_rf[rd] = ref_out[7:0];
        check("idle_ready", 16'(instr_ready), 16'd1);
        check("idle_we", 16'(write_enable), 16'd0);
        check("idle_done", 16'(done), 16'd0);
        check("rf_rd", 16'(rf[rd]), 16'(exp_rf[rd]));
        check("rf_other", 16'(rf[!rd]), 16'(exp_rf[!rd]));
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        exp_result  = 8'h00;
        exp_zero    = 1'b0;
        exp_carry   = 1'b0;
        exp_rf[0]   = 8'h00;
        exp_rf[1]   = 8'h00;
        @(negedge clock);
        @(negedge clock);
        check("rst_ready", 16'(instr_ready), 16'd1);
        check("rst_we", 16'(write_enable), 16'd0);
        check("rst_done", 16'(done), 16'd0);
        check("rst_result", 16'(result), 16'h00);
        check("rst_flags", 16'({zero_flag, carry_flag}), 16'd0);
        check("rst_selects", 16'({read_register1, read_register2, write_register}), 16'd0);
        check("rst_wdata", 16'(write_data), 16'h00);
        reset = 1'b0;
        @(negedge clock);

        run(6, 0, 0, 0, 8'h7F, 0);            // LDI r0,7F
        run(6, 1, 0, 0, 8'h81, 0);            // LDI r1,81
        run(1, 0, 0, 1, 8'h00, 0);            // ADD r0,r0,r1 -> 00, c=1, z=1
        check("add_rf0", 16'(rf[0]), 16'h00);
        run(6, 0, 0, 0, 8'h05, 0);
        run(6, 1, 0, 0, 8'h07, 1);
        run(2, 1, 0, 1, 8'h00, 0);            // SUB r1,r0,r1 -> FE, borrow
        check("sub_val", 16'(result), 16'hFE);
        run(7, 0, 1, 0, 8'h00, 0);            // SHL r0,r1 -> FC, c=1
        check("shl_val", 16'({carry_flag, result}), 16'h1FC);
        run(0, 1, 1, 1, 8'h55, 0);            // NOP keeps flags and result

        // Continuous valid with NOPs: ready returns exactly every 4th cycle.
        wait_ready();
        instr       = 16'h1C00;
        instr_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clock);
            check("thr_ready", 16'(instr_ready), 16'((c % 4) == 3));
            check("thr_done", 16'(done), 16'((c % 4) == 2));
            check("thr_we", 16'(write_enable), 16'd0);
        end
        instr_valid = 1'b0;
        check("thr_result", 16'(result), 16'(exp_result));
        check("thr_flags", 16'({zero_flag, carry_flag}), 16'({exp_zero, exp_carry}));

        // Asynchronous reset while an ADD sits in EXEC.
        @(negedge clock);
        wait_ready();
        instr       = {3'd1, 1'b1, 1'b0, 1'b1, 2'b00, 8'h00};
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", 16'(instr_ready), 16'd1);
        check("arst_we", 16'(write_enable), 16'd0);
        check("arst_done", 16'(done), 16'd0);
        check("arst_flags", 16'({zero_flag, carry_flag}), 16'd0);
        check("arst_result", 16'(result), 16'h00);
        @(negedge clock);
        reset = 1'b0;
        exp_result = 8'h00;
        exp_zero   = 1'b0;
        exp_carry  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("arst_no_we", 16'(write_enable), 16'd0);
        end
        check("arst_rf0", 16'(rf[0]), 16'(exp_rf[0]));
        check("arst_rf1", 16'(rf[1]), 16'(exp_rf[1]));

        run(6, 0, 0, 0, 8'h03, 0);
        run(6, 1, 0, 0, 8'h01, 0);
        run(5, 0, 0, 1, 8'h00, 0);            // XOR r0,r0,r1 -> 02
        check("xor_rf0", 16'(rf[0]), 16'h02);

        for (int i = 0; i < 40; i++) begin
            run(int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
